// File: rtl/tx_port_mutex_arbiter.sv
// All-or-nothing port mutex arbiter: each switch engine requests a set of PHY-TX FIFOs and is
// granted the whole set at once, round-robin, with an aging override for wide requests.
module tx_port_mutex_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_PORT     = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ*NUM_PORT-1:0] mutex_req,
    output logic [NUM_REQ*NUM_PORT-1:0] mutex_val,
    output logic [NUM_PORT-1:0]         port_busy,
    output logic [NUM_REQ-1:0]          starve,
    output logic [NUM_REQ-1:0]          proto_err,
    input  logic                        err_clr
);

    localparam int AGE_W = $clog2(STARVE_LIMIT) + 1;
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STARVE_LIMIT - 1);
    localparam logic [PTR_W:0]   SCAN_WRAP = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } req_state_e;

    // Handshake: an engine holds a non-zero mutex_req slice stable and owns those FIFOs exactly
    // while its mutex_val slice equals the request; dropping the request to zero releases them.
    req_state_e                  state_q [NUM_REQ];
    req_state_e                  state_d [NUM_REQ];
    logic [AGE_W-1:0]            age_q   [NUM_REQ];
    logic [AGE_W-1:0]            age_d   [NUM_REQ];
    logic [NUM_PORT-1:0]         req_a   [NUM_REQ];
    logic [NUM_REQ*NUM_PORT-1:0] val_q, val_d;
    logic [NUM_PORT-1:0]         busy_q, busy_d;
    logic [NUM_REQ-1:0]          starve_q, starve_d;
    logic [NUM_REQ-1:0]          err_q, err_d;
    logic [PTR_W-1:0]            rr_q, rr_d;

    logic [NUM_REQ-1:0]          elig, cand, gnt_oh, new_err;
    logic                        gnt_any, prio_any, starve_taken;
    logic [NUM_PORT-1:0]         prio_req;
    logic [PTR_W-1:0]            gnt_idx, scan_idx;
    logic [PTR_W:0]              scan;

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            req_a[r] = mutex_req[r*NUM_PORT +: NUM_PORT];
        end
    end

    // Grant selection: eligibility is judged against the registered busy map, so ports released
    // on this edge only become grantable on the next one.
    always_comb begin
        elig     = '0;
        cand     = '0;
        gnt_oh   = '0;
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        prio_any = 1'b0;
        prio_req = '0;
        scan     = '0;
        scan_idx = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            elig[r] = (state_q[r] == ST_WAIT) && (req_a[r] != '0) && ((req_a[r] & busy_q) == '0);
            if (starve_q[r]) begin
                prio_any = 1'b1;
                prio_req = req_a[r];
            end
        end
        cand = elig;
        if (prio_any) begin
            if ((elig & starve_q) != '0) begin
                cand = elig & starve_q;
            end else begin
                for (int r = 0; r < NUM_REQ; r++) begin
                    if ((req_a[r] & prio_req) != '0) begin
                        cand[r] = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_q} + (PTR_W + 1)'(i);
            if (scan >= SCAN_WRAP) begin
                scan = scan - SCAN_WRAP;
            end
            scan_idx = scan[PTR_W-1:0];
            if (!gnt_any && cand[scan_idx]) begin
                gnt_any          = 1'b1;
                gnt_oh[scan_idx] = 1'b1;
                gnt_idx          = scan_idx;
            end
        end
        rr_d = rr_q;
        if (gnt_any) begin
            rr_d = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Per-requester IDLE/WAIT/HOLD state machines plus aging and error tracking.
    always_comb begin
        val_d        = val_q;
        starve_d     = starve_q;
        new_err      = '0;
        starve_taken = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            state_d[r] = state_q[r];
            age_d[r]   = age_q[r];
            case (state_q[r])
                ST_IDLE: begin
                    val_d[r*NUM_PORT +: NUM_PORT] = '0;
                    if (req_a[r] != '0) begin
                        state_d[r] = ST_WAIT;
                        age_d[r]   = '0;
                    end
                end
                ST_WAIT: begin
                    if (req_a[r] == '0) begin
                        state_d[r]  = ST_IDLE;
                        starve_d[r] = 1'b0;
                    end else if (gnt_oh[r]) begin
                        state_d[r]  = ST_HOLD;
                        starve_d[r] = 1'b0;
                        val_d[r*NUM_PORT +: NUM_PORT] = req_a[r];
                    end else if (age_q[r] != AGE_MAX) begin
                        age_d[r] = age_q[r] + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (req_a[r] == '0) begin
                        state_d[r] = ST_IDLE;
                        val_d[r*NUM_PORT +: NUM_PORT] = '0;
                    end else if (req_a[r] != val_q[r*NUM_PORT +: NUM_PORT]) begin
                        state_d[r] = ST_WAIT;
                        age_d[r]   = '0;
                        new_err[r] = 1'b1;
                        val_d[r*NUM_PORT +: NUM_PORT] = '0;
                    end
                end
                default: begin
                    state_d[r] = ST_IDLE;
                    val_d[r*NUM_PORT +: NUM_PORT] = '0;
                end
            endcase
            // Only one priority requester at a time; the lowest aged index claims it.
            if ((starve_q == '0) && !starve_taken && (state_q[r] == ST_WAIT) && (req_a[r] != '0)
                && !gnt_oh[r] && (age_q[r] >= AGE_LIM)) begin
                starve_d[r]  = 1'b1;
                starve_taken = 1'b1;
            end
        end
        busy_d = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            busy_d = busy_d | val_d[r*NUM_PORT +: NUM_PORT];
        end
        err_d = (err_q & ~{NUM_REQ{err_clr}}) | new_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_q    <= '0;
            busy_q   <= '0;
            starve_q <= '0;
            err_q    <= '0;
            rr_q     <= '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                state_q[r] <= ST_IDLE;
                age_q[r]   <= '0;
            end
        end else begin
            val_q    <= val_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
            err_q    <= err_d;
            rr_q     <= rr_d;
            for (int r = 0; r < NUM_REQ; r++) begin
                state_q[r] <= state_d[r];
                age_q[r]   <= age_d[r];
            end
        end
    end

    assign mutex_val = val_q;
    assign port_busy = busy_q;
    assign starve    = starve_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_tx_port_mutex_arbiter.sv
// Directed bench for tx_port_mutex_arbiter: per-cycle vector table plus hand-written sequences
// for round-robin order, starvation override and reset during ownership.
module tb_tx_port_mutex_arbiter;

    localparam int NR = 4;
    localparam int NP = 4;
    localparam int W  = NR * NP;

    logic          clk = 1'b0;
    logic          rst;
    logic          err_clr;
    logic [W-1:0]  mutex_req;
    logic [W-1:0]  mutex_val;
    logic [NP-1:0] port_busy;
    logic [NR-1:0] starve;
    logic [NR-1:0] proto_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic         chk_en = 1'b0;
    logic [W-1:0] req_at_edge;

    always #5 clk = ~clk;

    tx_port_mutex_arbiter #(
        .NUM_REQ      (NR),
        .NUM_PORT     (NP),
        .STARVE_LIMIT (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mutex_req (mutex_req),
        .mutex_val (mutex_val),
        .port_busy (port_busy),
        .starve    (starve),
        .proto_err (proto_err),
        .err_clr   (err_clr)
    );

    typedef struct {
        logic        rst;
        logic        clr;
        logic [15:0] req;
        logic [15:0] val;
        logic [3:0]  busy;
        logic [3:0]  stv;
        logic [3:0]  err;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [NP-1:0] v);
        mutex_req[r*NP +: NP] = v;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        err_clr   = 1'b0;
        mutex_req = '0;
        step();
        rst = 1'b0;
    endtask

    // Every cycle: granted sets are pairwise disjoint and each is within the request sampled at that edge.
    always @(posedge clk) req_at_edge <= mutex_req;

    always @(negedge clk) begin
        if (chk_en) begin
            logic overlap;
            logic outside;
            overlap = 1'b0;
            outside = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if ((mutex_val[i*NP +: NP] & ~req_at_edge[i*NP +: NP]) != '0) outside = 1'b1;
                for (int j = i + 1; j < NR; j++) begin
                    if ((mutex_val[i*NP +: NP] & mutex_val[j*NP +: NP]) != '0) overlap = 1'b1;
                end
            end
            chk("inv_disjoint", {31'd0, overlap}, 32'd0);
            chk("inv_subset", {31'd0, outside}, 32'd0);
        end
    end

    initial begin
        rst       = 1'b1;
        err_clr   = 1'b0;
        mutex_req = '0;

        //           rst   clr   req       val       busy  stv   err
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0002, 16'h0000, 4'h0, 4'h0, 4'h0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0002, 16'h0002, 4'h2, 4'h0, 4'h0};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0};
        vecs[5]  = '{1'b0, 1'b0, 16'h0001, 16'h0000, 4'h0, 4'h0, 4'h0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0031, 16'h0001, 4'h1, 4'h0, 4'h0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0031, 16'h0001, 4'h1, 4'h0, 4'h0};
        vecs[8]  = '{1'b0, 1'b0, 16'h0031, 16'h0001, 4'h1, 4'h0, 4'h0};
        vecs[9]  = '{1'b0, 1'b0, 16'h0030, 16'h0000, 4'h0, 4'h0, 4'h0};
        vecs[10] = '{1'b0, 1'b0, 16'h0030, 16'h0030, 4'h3, 4'h0, 4'h0};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0};
        vecs[12] = '{1'b0, 1'b0, 16'h0400, 16'h0000, 4'h0, 4'h0, 4'h0};
        vecs[13] = '{1'b0, 1'b0, 16'h0400, 16'h0400, 4'h4, 4'h0, 4'h0};
        vecs[14] = '{1'b0, 1'b0, 16'h0800, 16'h0000, 4'h0, 4'h0, 4'h4};
        vecs[15] = '{1'b0, 1'b0, 16'h0800, 16'h0800, 4'h8, 4'h0, 4'h4};
        vecs[16] = '{1'b0, 1'b1, 16'h0800, 16'h0800, 4'h8, 4'h0, 4'h0};
        vecs[17] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0};
        vecs[18] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 4'h0, 4'h0, 4'h0};
        vecs[19] = '{1'b0, 1'b0, 16'h0100, 16'h0100, 4'h1, 4'h0, 4'h0};
        vecs[20] = '{1'b0, 1'b1, 16'h0200, 16'h0000, 4'h0, 4'h0, 4'h4};
        vecs[21] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0};

        for (int k = 0; k < 22; k++) begin
            rst       = vecs[k].rst;
            err_clr   = vecs[k].clr;
            mutex_req = vecs[k].req;
            step();
            chk($sformatf("vec%0d_val", k), {16'd0, mutex_val}, {16'd0, vecs[k].val});
            chk($sformatf("vec%0d_busy", k), {28'd0, port_busy}, {28'd0, vecs[k].busy});
            chk($sformatf("vec%0d_starve", k), {28'd0, starve}, {28'd0, vecs[k].stv});
            chk($sformatf("vec%0d_err", k), {28'd0, proto_err}, {28'd0, vecs[k].err});
            chk_en = 1'b1;
        end
        err_clr = 1'b0;

        // Round robin: requester 0 releases port 0 while 1..3 wait; then each releases in turn.
        do_reset();
        set_req(0, 4'b0001);
        step();
        step();
        chk("rr_first_owner", {16'd0, mutex_val}, 32'h0001);
        set_req(1, 4'b0001);
        set_req(2, 4'b0001);
        set_req(3, 4'b0001);
        step();
        set_req(0, 4'b0000);
        step();
        chk("rr_release_gap", {16'd0, mutex_val}, 32'h0000);
        set_req(0, 4'b0001);
        step();
        chk("rr_grant_1", {16'd0, mutex_val}, 32'h0010);
        set_req(1, 4'b0000);
        step();
        chk("rr_gap_after_1", {16'd0, mutex_val}, 32'h0000);
        step();
        chk("rr_grant_2", {16'd0, mutex_val}, 32'h0100);
        set_req(2, 4'b0000);
        step();
        step();
        chk("rr_grant_3", {16'd0, mutex_val}, 32'h1000);
        set_req(3, 4'b0000);
        step();
        step();
        chk("rr_grant_0_last", {16'd0, mutex_val}, 32'h0001);

        // Starvation: broadcast requester 3 against 0/1 alternately releasing and re-requesting.
        do_reset();
        set_req(0, 4'b0001);
        set_req(1, 4'b0010);
        set_req(3, 4'b1111);
        for (int n = 1; n <= 72; n++) begin
            step();
            if (n == 3)  chk("stv_initial_owners", {16'd0, mutex_val}, 32'h0021);
            if (n == 63) chk("stv_owners_pre", {16'd0, mutex_val}, 32'h0021);
            if (n == 64) chk("stv_not_yet", {28'd0, starve}, 32'h0);
            if (n == 65) chk("stv_set", {28'd0, starve}, 32'h8);
            if (n == 66) begin
                chk("stv_no_overlap_grant", {16'd0, mutex_val}, 32'h0020);
                chk("stv_held", {28'd0, starve}, 32'h8);
            end
            if (n == 68) begin
                chk("stv_broadcast_grant", {16'd0, mutex_val}, 32'hF000);
                chk("stv_cleared", {28'd0, starve}, 32'h0);
            end
            if (n == 72) begin
                chk("stv_broadcast_kept", {16'd0, mutex_val}, 32'hF000);
                chk("stv_busy_all", {28'd0, port_busy}, 32'hF);
            end
            if (n >= 3) begin
                case ((n - 3) % 6)
                    0: set_req(0, 4'b0000);
                    1: set_req(0, 4'b0001);
                    3: set_req(1, 4'b0000);
                    4: set_req(1, 4'b0010);
                    default: ;
                endcase
            end
        end

        // Reset while three requesters hold; afterwards grants restart from requester 0.
        do_reset();
        set_req(0, 4'b0001);
        set_req(1, 4'b0010);
        set_req(2, 4'b0100);
        for (int n = 0; n < 4; n++) step();
        chk("rst6_three_hold", {16'd0, mutex_val}, 32'h0421);
        rst = 1'b1;
        step();
        chk("rst6_val", {16'd0, mutex_val}, 32'h0000);
        chk("rst6_busy", {28'd0, port_busy}, 32'h0);
        chk("rst6_starve", {28'd0, starve}, 32'h0);
        chk("rst6_err", {28'd0, proto_err}, 32'h0);
        rst = 1'b0;
        set_req(3, 4'b1000);
        step();
        chk("rst6_wait", {16'd0, mutex_val}, 32'h0000);
        step();
        chk("rst6_grant0", {16'd0, mutex_val}, 32'h0001);
        step();
        chk("rst6_grant1", {16'd0, mutex_val}, 32'h0021);
        step();
        chk("rst6_grant2", {16'd0, mutex_val}, 32'h0421);
        step();
        chk("rst6_grant3", {16'd0, mutex_val}, 32'h8421);
        chk("rst6_busy_all", {28'd0, port_busy}, 32'hF);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
